// File: rtl/computer_pkg.sv
// Shared types and constants for the multi-cycle 16-bit computer:
// parameter defaults, opcode and stage enumerations, instruction field slices.
package computer_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT = 8;

  // Instruction field positions (R-type and I-type share op/rd)
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 9;
  localparam int RS_LSB  = 6;
  localparam int RT_LSB  = 3;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 9;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_LDI  = 4'h6,
    OP_LD   = 4'h7,
    OP_ST   = 4'h8,
    OP_BEQZ = 4'h9,
    OP_JMP  = 4'hA,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } stage_e;

endpackage

// File: rtl/mcpu.sv
// Non-pipelined multi-cycle CPU. Each instruction walks
// FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK; HALT is absorbing.
// Optional macro COMPUTER_TRACE_EN adds a simulation-only per-instruction trace.
module mcpu
  import computer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int NREGS  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [ADDR_W-1:0] pc_addr_o,
  input  logic [DATA_W-1:0] instruction_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_read_i,
  output logic [DATA_W-1:0] mem_data_write_o,
  output logic              mem_write_enabled_o,
  output logic              halted_o
);

  localparam int RA_W = $clog2(NREGS);

  stage_e            stage, stage_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic [DATA_W-1:0] alu_q, alu_d, mdr_q, mdr_d;
  logic              halted_q, halted_d;

  opcode_e           op_s;
  logic [DATA_W-1:0] imm_sext_s, alu_s;
  logic [ADDR_W-1:0] pc_plus1_s;
  logic [RA_W-1:0]   rf_ra1_s, rf_ra2_s, rf_wa_s;
  logic [DATA_W-1:0] rf_rd1_s, rf_rd2_s, rf_wd_s;
  logic              rf_we_s;

  assign op_s       = opcode_e'(ir_q[OP_MSB:OP_LSB]);
  assign imm_sext_s = {{(DATA_W-IMM_W){ir_q[IMM_MSB]}}, ir_q[IMM_MSB:IMM_LSB]};
  assign pc_plus1_s = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Port 2 supplies R[rd] for instructions that consume it, else R[rt]
  assign rf_ra1_s = ir_q[RS_LSB +: RA_W];
  assign rf_ra2_s = ((op_s == OP_ST) || (op_s == OP_BEQZ)) ? ir_q[RD_LSB +: RA_W]
                                                           : ir_q[RT_LSB +: RA_W];
  assign rf_wa_s  = ir_q[RD_LSB +: RA_W];

  register_file #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_RegisterFile (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .ra1_i  (rf_ra1_s),
    .ra2_i  (rf_ra2_s),
    .rd1_o  (rf_rd1_s),
    .rd2_o  (rf_rd2_s),
    .we_i   (rf_we_s),
    .wa_i   (rf_wa_s),
    .wd_i   (rf_wd_s)
  );

  // ALU: arithmetic results, sign-extended immediate, and PC targets
  always_comb begin
    alu_s = '0;
    case (op_s)
      OP_ADD:  alu_s = a_q + b_q;
      OP_SUB:  alu_s = a_q - b_q;
      OP_AND:  alu_s = a_q & b_q;
      OP_OR:   alu_s = a_q | b_q;
      OP_XOR:  alu_s = a_q ^ b_q;
      OP_LDI:  alu_s = imm_sext_s;
      OP_BEQZ: alu_s = {{(DATA_W-ADDR_W){1'b0}}, pc_plus1_s + imm_sext_s[ADDR_W-1:0]};
      OP_JMP:  alu_s = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
      default: alu_s = '0;
    endcase
  end

  // Stage sequencing and per-stage datapath updates
  always_comb begin
    stage_d  = stage;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    halted_d = halted_q;
    rf_we_s  = 1'b0;
    rf_wd_s  = alu_q;
    case (stage)
      FETCH: begin
        ir_d    = instruction_i;
        stage_d = DECODE;
      end
      DECODE: begin
        a_d     = rf_rd1_s;
        b_d     = rf_rd2_s;
        d_d     = rf_rd2_s;
        stage_d = EXECUTE;
      end
      EXECUTE: begin
        alu_d   = alu_s;
        stage_d = MEMORY;
      end
      MEMORY: begin
        if (op_s == OP_LD) begin
          mdr_d = mem_data_read_i;
        end else begin
          mdr_d = mdr_q;
        end
        stage_d = WRITEBACK;
      end
      WRITEBACK: begin
        stage_d = FETCH;
        case (op_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI: begin
            rf_we_s = 1'b1;
            rf_wd_s = alu_q;
            pc_d    = pc_plus1_s;
          end
          OP_LD: begin
            rf_we_s = 1'b1;
            rf_wd_s = mdr_q;
            pc_d    = pc_plus1_s;
          end
          OP_BEQZ: begin
            if (d_q == '0) begin
              pc_d = alu_q[ADDR_W-1:0];
            end else begin
              pc_d = pc_plus1_s;
            end
          end
          OP_JMP: begin
            pc_d = alu_q[ADDR_W-1:0];
          end
          OP_HALT: begin
            stage_d  = HALT;
            halted_d = 1'b1;
          end
          default: begin
            pc_d = pc_plus1_s;
          end
        endcase
      end
      HALT: begin
        stage_d = HALT;
      end
      default: begin
        stage_d = FETCH;
      end
    endcase
  end

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage    <= FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      alu_q    <= '0;
      mdr_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      stage    <= stage_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      halted_q <= halted_d;
    end
  end

  assign pc_addr_o           = pc_q;
  assign mem_addr_o          = a_q[ADDR_W-1:0];
  assign mem_data_write_o    = d_q;
  assign mem_write_enabled_o = (stage == MEMORY) && (op_s == OP_ST);
  assign halted_o            = halted_q;

`ifdef COMPUTER_TRACE_EN
  logic [31:0]       trace_cycle_q;
  logic              trace_we_q;
  logic [ADDR_W-1:0] trace_addr_q;
  logic [DATA_W-1:0] trace_rd_q;
  logic [DATA_W-1:0] trace_wd_q;

  // Capture memory activity and print one line per retired instruction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trace_cycle_q <= 32'd0;
      trace_we_q    <= 1'b0;
      trace_addr_q  <= '0;
      trace_rd_q    <= '0;
      trace_wd_q    <= '0;
    end else begin
      trace_cycle_q <= trace_cycle_q + 32'd1;
      if (stage == MEMORY) begin
        trace_we_q   <= mem_write_enabled_o;
        trace_addr_q <= mem_addr_o;
        trace_rd_q   <= mem_data_read_i;
        trace_wd_q   <= mem_data_write_o;
      end
      if (stage == WRITEBACK) begin
        $display("cyc=%0d pc=%0d ir=%b regs=%h %h %h %h %h %h %h %h",
                 trace_cycle_q, pc_q, ir_q,
                 u_RegisterFile.cpu_registers[0], u_RegisterFile.cpu_registers[1],
                 u_RegisterFile.cpu_registers[2], u_RegisterFile.cpu_registers[3],
                 u_RegisterFile.cpu_registers[4], u_RegisterFile.cpu_registers[5],
                 u_RegisterFile.cpu_registers[6], u_RegisterFile.cpu_registers[7]);
        if (trace_we_q) begin
          $display("    mem_addr=%h rdata=%h wdata=%h", trace_addr_q, trace_rd_q, trace_wd_q);
        end
      end
    end
  end
`endif

endmodule

// File: rtl/ram.sv
// Data RAM: combinational read, synchronous write. Contents survive reset.
module ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] memory [DEPTH];

  // Write on the clock edge while enabled
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      memory[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = memory[addr_i];

endmodule

// File: rtl/register_file.sv
// General-purpose register file: two combinational read ports, one write port.
// All registers clear on reset; register 0 is an ordinary register.
module register_file #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [AW-1:0]     ra1_i,
  input  logic [AW-1:0]     ra2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  input  logic              we_i,
  input  logic [AW-1:0]     wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  logic [DATA_W-1:0] cpu_registers [NREGS];

  // Register storage with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) begin
        cpu_registers[i] <= '0;
      end
    end else if (we_i) begin
      cpu_registers[wa_i] <= wd_i;
    end
  end

  assign rd1_o = cpu_registers[ra1_i];
  assign rd2_o = cpu_registers[ra2_i];

endmodule

// File: rtl/rom.sv
// Program ROM: combinational read. Contents are normally preloaded by the
// simulation environment; the load port allows a synchronous update.
module rom #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              load_en_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] memory [DEPTH];

  // Optional program load, unaffected by reset
  always_ff @(posedge clk_i) begin
    if (load_en_i) begin
      memory[load_addr_i] <= load_data_i;
    end
  end

  assign data_o = memory[addr_i];

endmodule

// File: rtl/computer_system.sv
// Top level: program ROM, data RAM and the multi-cycle CPU.
// Optional macro COMPUTER_TRACE_EN enables the CPU's simulation trace.
module computer_system
  import computer_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int ROM_DEPTH = 256,
  parameter int RAM_DEPTH = 256,
  parameter int NREGS     = 8
) (
  input  logic clk,
  input  logic rst,
  output logic halted
);

  logic [ADDR_W-1:0] pc_addr;
  logic [DATA_W-1:0] instruction;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] cur_memory_data;
  logic [DATA_W-1:0] mem_data_write;
  logic              mem_write_enabled;

  rom #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (ROM_DEPTH)
  ) u_ROM (
    .clk_i       (clk),
    .load_en_i   (1'b0),
    .load_addr_i ({ADDR_W{1'b0}}),
    .load_data_i ({DATA_W{1'b0}}),
    .addr_i      (pc_addr),
    .data_o      (instruction)
  );

  ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (RAM_DEPTH)
  ) u_RAM (
    .clk_i   (clk),
    .we_i    (mem_write_enabled),
    .addr_i  (mem_addr),
    .wdata_i (mem_data_write),
    .rdata_o (cur_memory_data)
  );

  mcpu #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_MCPU (
    .clk_i               (clk),
    .rst_ni              (rst),
    .pc_addr_o           (pc_addr),
    .instruction_i       (instruction),
    .mem_addr_o          (mem_addr),
    .mem_data_read_i     (cur_memory_data),
    .mem_data_write_o    (mem_data_write),
    .mem_write_enabled_o (mem_write_enabled),
    .halted_o            (halted)
  );

endmodule

// File: tb/tb_computer_system.sv
// Self-checking bench for computer_system: directed programs plus random
// programs compared against an instruction-level reference interpreter.
module tb_computer_system;
  import computer_pkg::*;

  logic clk;
  logic rst;
  logic halted;

  int n_vec;
  int n_err;

  // Reference model state (architectural level)
  logic [15:0] mrom [256];
  logic [15:0] mram [256];
  logic [15:0] mreg [8];
  logic [7:0]  mpc;
  bit          mhalt;

  computer_system dut (
    .clk    (clk),
    .rst    (rst),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [8:0] imm);
    return {op, rd, imm};
  endfunction

  task automatic hold_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      dut.u_ROM.memory[i] = 16'h0000;
      dut.u_RAM.memory[i] = 16'h0000;
      mrom[i] = 16'h0000;
      mram[i] = 16'h0000;
    end
  endtask

  task automatic put_rom(input int a, input logic [15:0] w);
    dut.u_ROM.memory[a] = w;
    mrom[a] = w;
  endtask

  task automatic put_ram(input int a, input logic [15:0] w);
    dut.u_RAM.memory[a] = w;
    mram[a] = w;
  endtask

  // Sequence: LDI r1,5; LDI r2,7; ADD r3,r1,r2; LDI r4,0; ST r3,[r4]; HALT
  task automatic load_add_store();
    put_rom(0, enc_i(4'h6, 3'd1, 9'd5));
    put_rom(1, enc_i(4'h6, 3'd2, 9'd7));
    put_rom(2, enc_r(4'h1, 3'd3, 3'd1, 3'd2));
    put_rom(3, enc_i(4'h6, 3'd4, 9'd0));
    put_rom(4, enc_r(4'h8, 3'd3, 3'd4, 3'd0));
    put_rom(5, 16'hF000);
  endtask

  // One architectural instruction step
  task automatic model_step();
    logic [15:0] ins;
    logic [3:0]  op;
    logic [2:0]  rd, rs, rt;
    logic [15:0] simm;
    logic [7:0]  npc;
    if (mhalt) return;
    ins  = mrom[mpc];
    op   = ins[15:12];
    rd   = ins[11:9];
    rs   = ins[8:6];
    rt   = ins[5:3];
    simm = {{7{ins[8]}}, ins[8:0]};
    npc  = mpc + 8'd1;
    case (op)
      4'h1: mreg[rd] = mreg[rs] + mreg[rt];
      4'h2: mreg[rd] = mreg[rs] - mreg[rt];
      4'h3: mreg[rd] = mreg[rs] & mreg[rt];
      4'h4: mreg[rd] = mreg[rs] | mreg[rt];
      4'h5: mreg[rd] = mreg[rs] ^ mreg[rt];
      4'h6: mreg[rd] = simm;
      4'h7: mreg[rd] = mram[mreg[rs][7:0]];
      4'h8: mram[mreg[rs][7:0]] = mreg[rd];
      4'h9: if (mreg[rd] == 16'h0000) npc = mpc + 8'd1 + simm[7:0];
      4'hA: npc = ins[7:0];
      4'hF: begin mhalt = 1'b1; npc = mpc; end
      default: ;
    endcase
    mpc = npc;
  endtask

  task automatic test_reset();
    int exp_stage;
    hold_reset();
    clear_mem();
    rst = 1'b1;
    #1;
    n_vec++;
    if (dut.pc_addr !== 8'd0) begin
      n_err++; $display("FAIL reset_pc got %h exp 00", dut.pc_addr);
    end
    n_vec++;
    if (dut.u_MCPU.stage !== FETCH) begin
      n_err++; $display("FAIL reset_stage got %0d exp 0", dut.u_MCPU.stage);
    end
    n_vec++;
    if (halted !== 1'b0) begin
      n_err++; $display("FAIL reset_halted got %b exp 0", halted);
    end
    for (int j = 0; j < 8; j++) begin
      n_vec++;
      if (dut.u_MCPU.u_RegisterFile.cpu_registers[j] !== 16'h0000) begin
        n_err++; $display("FAIL reset_reg r%0d got %h exp 0000", j, dut.u_MCPU.u_RegisterFile.cpu_registers[j]);
      end
    end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      exp_stage = i % 5;
      n_vec++;
      if (int'(dut.u_MCPU.stage) != exp_stage) begin
        n_err++; $display("FAIL stage_seq step %0d got %0d exp %0d", i, dut.u_MCPU.stage, exp_stage);
      end
    end
  endtask

  task automatic test_add_store();
    hold_reset();
    clear_mem();
    load_add_store();
    rst = 1'b1;
    repeat (29) @(negedge clk);
    n_vec++;
    if (halted !== 1'b0) begin
      n_err++; $display("FAIL halt_early got %b exp 0 at cycle 29", halted);
    end
    @(negedge clk);
    n_vec++;
    if (halted !== 1'b1) begin
      n_err++; $display("FAIL halt_at_30 got %b exp 1", halted);
    end
    n_vec++;
    if (dut.u_RAM.memory[0] !== 16'd12) begin
      n_err++; $display("FAIL add_store_ram0 got %h exp 000c", dut.u_RAM.memory[0]);
    end
    n_vec++;
    if (dut.pc_addr !== 8'd5) begin
      n_err++; $display("FAIL halt_pc got %h exp 05", dut.pc_addr);
    end
    for (int i = 1; i <= 9; i++) begin
      n_vec++;
      if (dut.u_RAM.memory[i] !== 16'h0000) begin
        n_err++; $display("FAIL ram_untouched [%0d] got %h exp 0000", i, dut.u_RAM.memory[i]);
      end
    end
  endtask

  task automatic test_sub_ldi();
    hold_reset();
    clear_mem();
    put_rom(0, enc_i(4'h6, 3'd1, 9'd0));
    put_rom(1, enc_i(4'h6, 3'd2, 9'd1));
    put_rom(2, enc_r(4'h2, 3'd3, 3'd1, 3'd2));
    put_rom(3, enc_i(4'h6, 3'd4, 9'h1FF));
    put_rom(4, 16'hF000);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    n_vec++;
    if (dut.u_MCPU.u_RegisterFile.cpu_registers[3] !== 16'hFFFF) begin
      n_err++; $display("FAIL sub_wrap r3 got %h exp ffff", dut.u_MCPU.u_RegisterFile.cpu_registers[3]);
    end
    n_vec++;
    if (dut.u_MCPU.u_RegisterFile.cpu_registers[4] !== 16'hFFFF) begin
      n_err++; $display("FAIL ldi_neg r4 got %h exp ffff", dut.u_MCPU.u_RegisterFile.cpu_registers[4]);
    end
    n_vec++;
    if (halted !== 1'b1) begin
      n_err++; $display("FAIL sub_halt got %b exp 1", halted);
    end
  endtask

  task automatic test_load();
    int we_seen;
    hold_reset();
    clear_mem();
    put_ram(2, 16'd9);
    put_rom(0, enc_i(4'h6, 3'd5, 9'd2));
    put_rom(1, enc_r(4'h7, 3'd6, 3'd5, 3'd0));
    put_rom(2, 16'hF000);
    rst = 1'b1;
    we_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (dut.mem_write_enabled !== 1'b0) we_seen++;
    end
    n_vec++;
    if (dut.u_MCPU.u_RegisterFile.cpu_registers[6] !== 16'd9) begin
      n_err++; $display("FAIL load_r6 got %h exp 0009", dut.u_MCPU.u_RegisterFile.cpu_registers[6]);
    end
    n_vec++;
    if (we_seen != 0) begin
      n_err++; $display("FAIL load_no_write we cycles got %0d exp 0", we_seen);
    end
  endtask

  task automatic test_countdown();
    int taken;
    int prev_pc;
    int cyc;
    hold_reset();
    clear_mem();
    put_ram(1, 16'hAAAA);
    put_rom(0, enc_i(4'h6, 3'd1, 9'd3));
    put_rom(1, enc_i(4'h6, 3'd2, 9'd1));
    put_rom(2, enc_r(4'h2, 3'd1, 3'd1, 3'd2));
    put_rom(3, enc_i(4'h9, 3'd1, 9'd1));
    put_rom(4, 16'hA002);
    put_rom(5, enc_r(4'h8, 3'd1, 3'd2, 3'd0));
    put_rom(6, 16'hF000);
    rst = 1'b1;
    taken = 0;
    prev_pc = -1;
    cyc = 0;
    while (halted !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (dut.u_MCPU.stage == DECODE) begin
        if (prev_pc == 3 && int'(dut.pc_addr) == 5) taken++;
        prev_pc = int'(dut.pc_addr);
      end
    end
    n_vec++;
    if (halted !== 1'b1) begin
      n_err++; $display("FAIL countdown_timeout halted %b after %0d cycles exp 1", halted, cyc);
    end
    n_vec++;
    if (cyc != 60) begin
      n_err++; $display("FAIL countdown_cycles got %0d exp 60", cyc);
    end
    n_vec++;
    if (dut.u_RAM.memory[1] !== 16'h0000) begin
      n_err++; $display("FAIL countdown_ram1 got %h exp 0000", dut.u_RAM.memory[1]);
    end
    n_vec++;
    if (taken != 1) begin
      n_err++; $display("FAIL beqz_taken got %0d exp 1", taken);
    end
  endtask

  task automatic test_reset_mid_store();
    hold_reset();
    clear_mem();
    load_add_store();
    put_ram(0, 16'h5555);
    rst = 1'b1;
    repeat (23) @(negedge clk);
    n_vec++;
    if (dut.u_MCPU.stage !== MEMORY || dut.mem_write_enabled !== 1'b1) begin
      n_err++; $display("FAIL store_in_memory stage %0d we %b exp 3 1", dut.u_MCPU.stage, dut.mem_write_enabled);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (dut.pc_addr !== 8'd0 || dut.u_MCPU.stage !== FETCH) begin
      n_err++; $display("FAIL async_reset pc %h stage %0d exp 00 0", dut.pc_addr, dut.u_MCPU.stage);
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (dut.u_RAM.memory[0] !== 16'h5555) begin
      n_err++; $display("FAIL aborted_store ram0 got %h exp 5555", dut.u_RAM.memory[0]);
    end
    rst = 1'b1;
    repeat (30) @(negedge clk);
    n_vec++;
    if (dut.u_RAM.memory[0] !== 16'd12 || halted !== 1'b1) begin
      n_err++; $display("FAIL rerun ram0 %h halted %b exp 000c 1", dut.u_RAM.memory[0], halted);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [3:0]  op;
    for (int t = 0; t < 6; t++) begin
      hold_reset();
      clear_mem();
      for (int a = 0; a < 256; a++) begin
        r  = $urandom;
        op = r[15:12];
        if (op == 4'hF && r[18:16] != 3'd0) op = 4'h6;
        put_rom(a, {op, r[11:0]});
        r = $urandom;
        put_ram(a, r[15:0]);
      end
      for (int j = 0; j < 8; j++) mreg[j] = 16'h0000;
      mpc   = 8'd0;
      mhalt = 1'b0;
      rst   = 1'b1;
      for (int k = 0; k < 60; k++) begin
        repeat (5) @(negedge clk);
        model_step();
        n_vec++;
        if (dut.pc_addr !== mpc) begin
          n_err++; $display("FAIL rand_pc t%0d i%0d got %h exp %h", t, k, dut.pc_addr, mpc);
        end
        n_vec++;
        if (halted !== mhalt) begin
          n_err++; $display("FAIL rand_halt t%0d i%0d got %b exp %b", t, k, halted, mhalt);
        end
        for (int j = 0; j < 8; j++) begin
          n_vec++;
          if (dut.u_MCPU.u_RegisterFile.cpu_registers[j] !== mreg[j]) begin
            n_err++; $display("FAIL rand_reg t%0d i%0d r%0d got %h exp %h", t, k, j,
                              dut.u_MCPU.u_RegisterFile.cpu_registers[j], mreg[j]);
          end
        end
      end
      for (int a = 0; a < 256; a++) begin
        n_vec++;
        if (dut.u_RAM.memory[a] !== mram[a]) begin
          n_err++; $display("FAIL rand_ram t%0d [%0d] got %h exp %h", t, a, dut.u_RAM.memory[a], mram[a]);
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    test_reset();
    test_add_store();
    test_sub_ldi();
    test_load();
    test_countdown();
    test_reset_mid_store();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
